// File: rtl/dc_offset_pkg.sv
// Shared types and helpers for the DC offset tracker: tracker FSM states,
// crossing detection, saturation selection and accumulator sizing.
package dc_offset_pkg;

    typedef enum logic [1:0] {
        ARM = 2'd0,
        POS = 2'd1,
        NEG = 2'd2
    } trk_state_e;

    typedef enum logic [1:0] {
        SAT_PASS = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_sel_e;

    // Accumulator holds 2^log2_ncyc sums of (max+min), each W+1 bits wide.
    function automatic int acc_width(input int w, input int log2_ncyc);
        return w + 1 + log2_ncyc;
    endfunction

    function automatic logic is_rise(input logic prev_neg, input logic cur_neg);
        return prev_neg & ~cur_neg;
    endfunction

    function automatic logic is_fall(input logic prev_neg, input logic cur_neg);
        return ~prev_neg & cur_neg;
    endfunction

    // ext_msb/res_msb are the top two bits of a one-bit-wider result.
    function automatic sat_sel_e sat_select(input logic ext_msb, input logic res_msb);
        if (ext_msb == res_msb) begin
            return SAT_PASS;
        end
        return ext_msb ? SAT_LO : SAT_HI;
    endfunction

endpackage

// File: rtl/dc_offset_tracker_if.sv
// Sample-side bus of the DC offset tracker: valid-gated input samples in,
// corrected samples, offsets and lock flags out.
interface dc_offset_tracker_if #(
    parameter int W  = 14,
    parameter int CH = 3
);
    logic            in_valid;
    logic [CH*W-1:0] vin;
    logic            out_valid;
    logic [CH*W-1:0] vout;
    logic [CH*W-1:0] offset;
    logic [CH-1:0]   locked;

    modport master (
        output in_valid, vin,
        input  out_valid, vout, offset, locked
    );

    modport slave (
        input  in_valid, vin,
        output out_valid, vout, offset, locked
    );
endinterface

// File: rtl/dc_offset_chan.sv
// One channel of the DC offset tracker: crossing-driven peak FSM, period
// accumulator, zero-crossing timeout and offset correction.
// DC_OFFSET_SAT_EN selects saturating instead of wrapping correction.
//
// state | meaning
// ARM   | waiting for the first rising crossing
// POS   | positive half-period, tracking max
// NEG   | negative half-period, tracking min; next rise closes the period
module dc_offset_chan
    import dc_offset_pkg::*;
#(
    parameter int W         = 14,
    parameter int LOG2_NCYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic signed [W-1:0] i_sample,
    output logic signed [W-1:0] o_vout,
    output logic signed [W-1:0] o_offset,
    output logic                o_locked
);
    localparam int ACC_W  = acc_width(W, LOG2_NCYC);
    localparam int PCNT_W = LOG2_NCYC + 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'((1 << LOG2_NCYC) - 1);
    localparam logic [TCNT_W-1:0] TCNT_LOAD = TCNT_W'(TIMEOUT);

    trk_state_e              r_state, w_state_nxt;
    logic                    r_prev_neg;
    logic signed [W-1:0]     r_max, w_max_nxt;
    logic signed [W-1:0]     r_min, w_min_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [PCNT_W-1:0]       r_pcnt, w_pcnt_nxt;
    logic [TCNT_W-1:0]       r_tleft, w_tleft_nxt;
    logic signed [W-1:0]     r_offset, w_offset_nxt;
    logic                    r_locked, w_locked_nxt;
    logic signed [W-1:0]     r_vout;

    logic                    w_rise, w_fall, w_tmo;
    logic signed [ACC_W-1:0] w_mid, w_sum;
    logic signed [W-1:0]     w_offset_new, w_corr;

    assign w_rise = is_rise(r_prev_neg, i_sample[W-1]);
    assign w_fall = is_fall(r_prev_neg, i_sample[W-1]);
    // Timer runs down from TIMEOUT; reaching 1 before this sample means TIMEOUT samples seen.
    assign w_tmo  = (r_tleft == TCNT_W'(1));

    assign w_mid = $signed({{(ACC_W-W){r_max[W-1]}}, r_max})
                 + $signed({{(ACC_W-W){r_min[W-1]}}, r_min});
    assign w_sum = r_acc + w_mid;
    assign w_offset_new = W'(w_sum >>> (LOG2_NCYC + 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_max_nxt    = r_max;
        w_min_nxt    = r_min;
        w_acc_nxt    = r_acc;
        w_pcnt_nxt   = r_pcnt;
        w_tleft_nxt  = r_tleft;
        w_offset_nxt = r_offset;
        w_locked_nxt = r_locked;
        if (i_valid) begin
            if (w_rise || w_fall) begin
                w_tleft_nxt = TCNT_LOAD;
            end else if (r_tleft != '0) begin
                w_tleft_nxt = r_tleft - 1'b1;
            end
            unique case (r_state)
                ARM: begin
                    if (w_rise) begin
                        w_state_nxt = POS;
                        w_max_nxt   = i_sample;
                    end
                end
                POS: begin
                    if (w_fall) begin
                        w_state_nxt = NEG;
                        w_min_nxt   = i_sample;
                    end else if (w_tmo) begin
                        w_state_nxt  = ARM;
                        w_acc_nxt    = '0;
                        w_pcnt_nxt   = '0;
                        w_max_nxt    = '0;
                        w_min_nxt    = '0;
                        w_locked_nxt = 1'b0;
                    end else if (i_sample > r_max) begin
                        w_max_nxt = i_sample;
                    end
                end
                NEG: begin
                    if (w_rise) begin
                        w_state_nxt = POS;
                        w_max_nxt   = i_sample;
                        if (r_pcnt == PCNT_LAST) begin
                            w_offset_nxt = w_offset_new;
                            w_acc_nxt    = '0;
                            w_pcnt_nxt   = '0;
                            w_locked_nxt = 1'b1;
                        end else begin
                            w_acc_nxt  = w_sum;
                            w_pcnt_nxt = r_pcnt + 1'b1;
                        end
                    end else if (w_tmo) begin
                        w_state_nxt  = ARM;
                        w_acc_nxt    = '0;
                        w_pcnt_nxt   = '0;
                        w_max_nxt    = '0;
                        w_min_nxt    = '0;
                        w_locked_nxt = 1'b0;
                    end else if (i_sample < r_min) begin
                        w_min_nxt = i_sample;
                    end
                end
                default: w_state_nxt = ARM;
            endcase
        end
    end

`ifdef DC_OFFSET_SAT_EN
    logic signed [W:0] w_diff;
    assign w_diff = {i_sample[W-1], i_sample} - {r_offset[W-1], r_offset};
    always_comb begin
        unique case (sat_select(w_diff[W], w_diff[W-1]))
            SAT_HI:  w_corr = {1'b0, {(W-1){1'b1}}};
            SAT_LO:  w_corr = {1'b1, {(W-1){1'b0}}};
            default: w_corr = w_diff[W-1:0];
        endcase
    end
`else
    assign w_corr = i_sample - r_offset;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_neg <= 1'b0;
            r_max      <= '0;
            r_min      <= '0;
            r_acc      <= '0;
            r_pcnt     <= '0;
            r_tleft    <= TCNT_LOAD;
            r_offset   <= '0;
            r_locked   <= 1'b0;
            r_vout     <= '0;
        end else begin
            r_max    <= w_max_nxt;
            r_min    <= w_min_nxt;
            r_acc    <= w_acc_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_tleft  <= w_tleft_nxt;
            r_offset <= w_offset_nxt;
            r_locked <= w_locked_nxt;
            if (i_valid) begin
                r_prev_neg <= i_sample[W-1];
                r_vout     <= w_corr;
            end
        end
    end

    assign o_vout   = r_vout;
    assign o_offset = r_offset;
    assign o_locked = r_locked;

endmodule

// File: rtl/dc_offset_tracker.sv
// Multi-channel DC offset remover: CH independent trackers sharing one valid.
// DC_OFFSET_SAT_EN selects saturating instead of wrapping correction.
module dc_offset_tracker
    import dc_offset_pkg::*;
#(
    parameter int W         = 14,
    parameter int CH        = 3,
    parameter int LOG2_NCYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    dc_offset_tracker_if.slave bus
);
    logic                r_out_valid;
    logic signed [W-1:0] w_vout   [CH];
    logic signed [W-1:0] w_offset [CH];
    logic [CH-1:0]       w_locked;
    logic [CH*W-1:0]     w_vout_bus, w_offset_bus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_chan
        dc_offset_chan #(
            .W         (W),
            .LOG2_NCYC (LOG2_NCYC),
            .TIMEOUT   (TIMEOUT)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_valid  (bus.in_valid),
            .i_sample (bus.vin[k*W +: W]),
            .o_vout   (w_vout[k]),
            .o_offset (w_offset[k]),
            .o_locked (w_locked[k])
        );
    end

    always_comb begin
        w_vout_bus   = '0;
        w_offset_bus = '0;
        for (int k = 0; k < CH; k++) begin
            w_vout_bus[k*W +: W]   = w_vout[k];
            w_offset_bus[k*W +: W] = w_offset[k];
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.vout      = w_vout_bus;
    assign bus.offset    = w_offset_bus;
    assign bus.locked    = w_locked;

endmodule
